// File: rtl/fetch_pkg.sv
// Shared state encoding, bus tag fields, FIFO entry type and line-geometry helpers
// for the burst instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // Tag layout from the MSB down: read/write bit, then a 4-bit transaction type, zeros below.
  localparam logic       TAG_READ   = 1'b1;
  localparam logic [3:0] TAG_MEMORY = 4'b0001;
  localparam int         TAG_TYPE_W = 4;

  localparam int ENTRY_PC_W    = 64;
  localparam int ENTRY_INSTR_W = 32;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0]    pc;
    logic [ENTRY_INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic int calc_ipb(input int bus_w, input int instr_w);
    return bus_w / instr_w;
  endfunction

  function automatic int calc_line_bytes(input int beats, input int bus_w);
    return beats * bus_w / 8;
  endfunction

  function automatic int calc_line_instrs(input int beats, input int bus_w, input int instr_w);
    return beats * (bus_w / instr_w);
  endfunction

  function automatic int unsigned read_mem_tag(input int tag_w);
    return (32'(TAG_READ) << (tag_w - 1)) | (32'(TAG_MEMORY) << (tag_w - 1 - TAG_TYPE_W));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: up to NPUSH compacted writes plus one show-ahead read per cycle, with flush.
// A push is visible at the head one cycle later; no backpressure, the writer reserves space.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int NPUSH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic [NPUSH-1:0]       push_vld_i,
  input  fetch_entry_t           push_dat_i [NPUSH],
  input  logic                   pop_i,
  output logic                   head_vld_o,
  output fetch_entry_t           head_dat_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] push_n;
  logic [PW-1:0] wr_idx [NPUSH];
  logic          pop_ok;
  logic [CW:0]   fill_next;

  assign head_vld_o = (count_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign pop_ok     = pop_i & head_vld_o;
  assign fill_next  = {1'b0, count_q} + {1'b0, push_n} - (CW + 1)'(pop_ok);

  // Valid lanes are packed into consecutive slots so gaps never reach the read side.
  always_comb begin
    push_n = '0;
    for (int k = 0; k < NPUSH; k++) begin
      wr_idx[k] = wr_ptr_q + PW'(push_n);
      if (push_vld_i[k]) push_n = push_n + CW'(1);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push_n);
      rd_ptr_d = rd_ptr_q + PW'(pop_ok);
      count_d  = count_q + push_n - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NPUSH; k++) begin
      if (!flush_i && push_vld_i[k]) mem_q[wr_idx[k]] <= push_dat_i[k];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !flush_i |-> (fill_next <= (CW + 1)'(DEPTH)));

endmodule

// File: rtl/fetch_burst_unit.sv
// Burst fetch front end: line reads on Sysbus, each beat unpacked with PCs into a prefetch FIFO.
// Request issues once a whole line of FIFO space is free; beats are always acked; output is valid/ready.
module fetch_burst_unit
  import fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int ADDR_WIDTH     = 64,
  parameter int INSTR_WIDTH    = 32,
  parameter int BURST_BEATS    = 8,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     entry,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  input  logic                      redirect_valid,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic                      instr_valid,
  output logic [INSTR_WIDTH-1:0]    instr,
  output logic [ADDR_WIDTH-1:0]     instr_pc,
  input  logic                      instr_ready
);

  localparam int IPB         = calc_ipb(BUS_DATA_WIDTH, INSTR_WIDTH);
  localparam int LINE_BYTES  = calc_line_bytes(BURST_BEATS, BUS_DATA_WIDTH);
  localparam int LINE_INSTRS = calc_line_instrs(BURST_BEATS, BUS_DATA_WIDTH, INSTR_WIDTH);
  localparam int INSTR_BYTES = INSTR_WIDTH / 8;
  localparam int BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_WIDTH-1:0]    LINE_MASK  = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0]    LINE_STEP  = ADDR_WIDTH'(LINE_BYTES);
  localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG    = BUS_TAG_WIDTH'(read_mem_tag(BUS_TAG_WIDTH));
  localparam logic [CNT_W-1:0]         LINE_SLOTS = CNT_W'(LINE_INSTRS);
  localparam logic [CNT_W-1:0]         FIFO_SLOTS = CNT_W'(FIFO_DEPTH);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                  redir_pend_q, redir_pend_d;

  logic [ADDR_WIDTH-1:0] slot_pc  [IPB];
  fetch_entry_t          beat_ent [IPB];
  logic [IPB-1:0]        keep;
  logic [IPB-1:0]        push_vld;
  logic                  beat_last;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      free_slots;
  logic                  head_vld;
  fetch_entry_t          head_dat;

  assign beat_last  = (beat_cnt_q == BEAT_W'(BURST_BEATS - 1));
  assign free_slots = FIFO_SLOTS - fifo_count;

  // Slots below fetch_pc belong to the part of the line before an unaligned target.
  always_comb begin
    for (int k = 0; k < IPB; k++) begin
      slot_pc[k]        = req_addr_q + ADDR_WIDTH'((int'(beat_cnt_q) * IPB + k) * INSTR_BYTES);
      beat_ent[k].pc    = ENTRY_PC_W'(slot_pc[k]);
      beat_ent[k].instr = ENTRY_INSTR_W'(bus_resp[k*INSTR_WIDTH +: INSTR_WIDTH]);
      keep[k]           = (slot_pc[k] >= fetch_pc_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_addr_d   = req_addr_q;
    beat_cnt_d   = beat_cnt_q;
    redir_pend_d = redir_pend_q;
    bus_reqcyc   = 1'b0;
    bus_req      = '0;
    bus_reqtag   = '0;
    bus_respack  = 1'b0;
    push_vld     = '0;

    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && free_slots >= LINE_SLOTS) begin
          state_d      = REQ;
          req_addr_d   = fetch_pc_q & ~LINE_MASK;
          redir_pend_d = 1'b0;
        end
      end
      REQ: begin
        bus_reqcyc = 1'b1;
        bus_req    = BUS_DATA_WIDTH'(req_addr_q);
        bus_reqtag = REQ_TAG;
        if (redirect_valid) redir_pend_d = 1'b1;
        if (bus_reqack) begin
          beat_cnt_d   = '0;
          redir_pend_d = 1'b0;
          state_d      = (redir_pend_q || redirect_valid) ? DRAIN : RESP;
        end
      end
      RESP: begin
        bus_respack = bus_respcyc;
        if (bus_respcyc) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (!redirect_valid) push_vld = keep;
          if (beat_last) begin
            state_d    = IDLE;
            fetch_pc_d = req_addr_q + LINE_STEP;
          end
        end
        // A beat landing with the redirect still counts toward the burst, so a final beat ends it here.
        if (redirect_valid && !(bus_respcyc && beat_last)) state_d = DRAIN;
      end
      DRAIN: begin
        bus_respack = bus_respcyc;
        if (bus_respcyc) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (beat_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) fetch_pc_d = redirect_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= entry;
      req_addr_q   <= '0;
      beat_cnt_q   <= '0;
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_addr_q   <= req_addr_d;
      beat_cnt_q   <= beat_cnt_d;
      redir_pend_q <= redir_pend_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .NPUSH (IPB)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .flush_i    (redirect_valid),
    .push_vld_i (push_vld),
    .push_dat_i (beat_ent),
    .pop_i      (instr_ready),
    .head_vld_o (head_vld),
    .head_dat_o (head_dat),
    .count_o    (fifo_count)
  );

  assign instr_valid = head_vld;
  assign instr       = head_vld ? INSTR_WIDTH'(head_dat.instr) : '0;
  assign instr_pc    = head_vld ? ADDR_WIDTH'(head_dat.pc) : '0;

  a_resp_tag: assert property (@(posedge clk) disable iff (!reset)
    (state_q == RESP && bus_respcyc) |-> (bus_resptag == REQ_TAG));

endmodule

// File: tb/tb_fetch_burst_unit.sv
// Directed bench for fetch_burst_unit: aligned/unaligned entry, FIFO reservation,
// redirects in RESP and REQ, and asynchronous reset mid-burst.
module tb_fetch_burst_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;
  logic [63:0] q_pc [$];
  logic [31:0] q_in [$];

  always #5 clk = ~clk;

  fetch_burst_unit dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .bus_reqcyc     (bus_reqcyc),
    .bus_req        (bus_req),
    .bus_reqtag     (bus_reqtag),
    .bus_reqack     (bus_reqack),
    .bus_respcyc    (bus_respcyc),
    .bus_resp       (bus_resp),
    .bus_resptag    (bus_resptag),
    .bus_respack    (bus_respack),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  // Records every completed output handshake in order.
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready) begin
      q_pc.push_back(instr_pc);
      q_in.push_back(instr);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ival(input logic [63:0] p);
    return p[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [63:0] exp_addr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus_reqcyc) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, 64'(ok), 64'd1);
    check({tag, "_addr"}, bus_req, exp_addr);
  endtask

  task automatic ack_req(input string tag, input int delay, input logic [63:0] exp_addr);
    for (int d = 0; d < delay; d++) begin
      step();
      @(negedge clk);
      check({tag, "_held"}, {bus_reqcyc, bus_req[62:0]}, {1'b1, exp_addr[62:0]});
    end
    bus_reqack = 1'b1;
    step();
    bus_reqack = 1'b0;
  endtask

  task automatic send_beats(input string tag, input logic [63:0] line, input int first, input int last);
    logic [63:0] p;
    for (int b = first; b <= last; b++) begin
      p = line + 64'(8 * b);
      bus_respcyc = 1'b1;
      bus_resp    = {ival(p + 64'd4), ival(p)};
      @(negedge clk);
      check($sformatf("%s_ack%0d", tag, b), 64'(bus_respack), 64'd1);
      step();
    end
    bus_respcyc = 1'b0;
    bus_resp    = '0;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (q_pc.size() >= n) break;
    end
    repeat (4) step();
  endtask

  task automatic check_stream(input string tag, input int n, input logic [63:0] first_pc);
    logic [63:0] p;
    check({tag, "_count"}, 64'(q_pc.size()), 64'(n));
    for (int i = 0; i < n && i < q_pc.size(); i++) begin
      p = first_pc + 64'(4 * i);
      check($sformatf("%s_pc%0d", tag, i), q_pc[i], p);
      check($sformatf("%s_in%0d", tag, i), 64'(q_in[i]), 64'(ival(p)));
    end
  endtask

  initial begin
    int hi_cnt;
    reset          = 1'b0;
    entry          = 64'h1000;
    bus_reqack     = 1'b0;
    bus_respcyc    = 1'b1;
    bus_resp       = '0;
    bus_resptag    = 13'h1100;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;

    // Reset state
    repeat (3) step();
    check("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
    check("rst_req", bus_req, 64'd0);
    check("rst_reqtag", 64'(bus_reqtag), 64'd0);
    check("rst_respack", 64'(bus_respack), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_pc", instr_pc, 64'd0);
    bus_respcyc = 1'b0;
    reset = 1'b1;

    // Aligned entry: request in the first cycle after reset release
    @(negedge clk);
    check("s1_reqcyc_pre", 64'(bus_reqcyc), 64'd0);
    @(negedge clk);
    check("s1_reqcyc", 64'(bus_reqcyc), 64'd1);
    check("s1_req", bus_req, 64'h1000);
    check("s1_tag", 64'(bus_reqtag), 64'h1100);
    ack_req("s1", 2, 64'h1000);
    send_beats("s1", 64'h1000, 0, 7);
    wait_n(16);
    check_stream("s1", 16, 64'h1000);
    check("s1_next_req", {bus_reqcyc, bus_req[62:0]}, {1'b1, 63'h1040});
    check("s1_empty", 64'(instr_valid), 64'd0);

    // Reset while a request is pending; unaligned entry
    entry = 64'h1008;
    reset = 1'b0;
    #1;
    check("s2_rst_reqcyc", 64'(bus_reqcyc), 64'd0);
    check("s2_rst_req", bus_req, 64'd0);
    repeat (2) step();
    q_pc.delete();
    q_in.delete();
    reset = 1'b1;
    wait_req("s2_req", 64'h1000);
    ack_req("s2", 0, 64'h1000);
    send_beats("s2", 64'h1000, 0, 7);
    wait_n(14);
    check_stream("s2", 14, 64'h1008);

    // Stalled consumer: two bursts fill the FIFO, then no request until 16 pops
    instr_ready = 1'b0;
    wait_req("s3_req1", 64'h1040);
    ack_req("s3a", 0, 64'h1040);
    send_beats("s3a", 64'h1040, 0, 7);
    wait_req("s3_req2", 64'h1080);
    ack_req("s3b", 0, 64'h1080);
    send_beats("s3b", 64'h1080, 0, 7);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_reqcyc) hi_cnt++;
    end
    check("s3_no_req_full", 64'(hi_cnt), 64'd0);
    check("s3_head_valid", 64'(instr_valid), 64'd1);
    check("s3_head_pc", instr_pc, 64'h1040);
    step();
    q_pc.delete();
    q_in.delete();
    instr_ready = 1'b1;
    wait_req("s3_req3", 64'h10C0);
    check("s3_head_at_req", instr_pc, 64'h1084);

    // Redirect after beat 3: remaining beats acked and dropped
    ack_req("s4", 1, 64'h10C0);
    send_beats("s4a", 64'h10C0, 0, 3);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2004;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("s4_flush_valid", 64'(instr_valid), 64'd0);
    q_pc.delete();
    q_in.delete();
    step();
    send_beats("s4d", 64'h10C0, 4, 7);
    @(negedge clk);
    check("s4_drain_valid", 64'(instr_valid), 64'd0);
    check("s4_drain_count", 64'(q_pc.size()), 64'd0);
    wait_req("s4_req", 64'h2000);
    ack_req("s4r", 0, 64'h2000);
    send_beats("s4r", 64'h2000, 0, 7);
    wait_n(15);
    check("s4_count", 64'(q_pc.size()), 64'd15);
    if (q_pc.size() > 0) begin
      check("s4_first_pc", q_pc[0], 64'h2004);
      check("s4_first_in", 64'(q_in[0]), 64'(ival(64'h2004)));
      check("s4_last_pc", q_pc[q_pc.size()-1], 64'h203C);
    end

    // Redirect while the request waits for ack
    wait_req("s5_req", 64'h2040);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3008;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("s5_held", {bus_reqcyc, bus_req[62:0]}, {1'b1, 63'h2040});
    q_pc.delete();
    q_in.delete();
    ack_req("s5", 2, 64'h2040);
    send_beats("s5d", 64'h2040, 0, 7);
    @(negedge clk);
    check("s5_drain_valid", 64'(instr_valid), 64'd0);
    check("s5_drain_count", 64'(q_pc.size()), 64'd0);
    wait_req("s5_next", 64'h3000);

    // Asynchronous reset in the middle of a response burst
    ack_req("s6", 0, 64'h3000);
    send_beats("s6", 64'h3000, 0, 2);
    entry       = 64'h4000;
    bus_respcyc = 1'b1;
    bus_resp    = {ival(64'h301C), ival(64'h3018)};
    reset       = 1'b0;
    #1;
    check("s6_rst_respack", 64'(bus_respack), 64'd0);
    check("s6_rst_reqcyc", 64'(bus_reqcyc), 64'd0);
    check("s6_rst_valid", 64'(instr_valid), 64'd0);
    check("s6_rst_instr", 64'(instr), 64'd0);
    check("s6_rst_pc", instr_pc, 64'd0);
    repeat (2) step();
    reset = 1'b1;
    @(negedge clk);
    check("s6_post_respack0", 64'(bus_respack), 64'd0);
    step();
    @(negedge clk);
    check("s6_post_respack1", 64'(bus_respack), 64'd0);
    bus_respcyc = 1'b0;
    wait_req("s6_req", 64'h4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
